// File: rtl/debounce_multi.sv
// Multi-channel input conditioner: each channel has a synchroniser, a stability filter,
// a registered debounced level, and one-cycle rise/fall pulses.
// Optional: define DEBOUNCE_FALL_EV_EN to build the fall_o pulse registers (otherwise fall_o is 0).
`timescale 1ns/1ps

module debounce_multi #(
    parameter int CH          = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STABLE_CNT  = 1000000
) (
    input  logic          clk100_i,
    input  logic          rstn_i,
    input  logic [CH-1:0] ev_i,
    output logic [CH-1:0] level_o,
    output logic [CH-1:0] rise_o,
    output logic [CH-1:0] fall_o
);

    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_reg;
        logic [CNT_W-1:0]       cnt_reg;
        logic                   level_reg;
        logic                   rise_reg;
        logic                   sync_s;
        logic                   differ;
        logic                   accept;

        assign sync_s = sync_reg[SYNC_STAGES-1];
        assign differ = (sync_s != level_reg);
        // A differing value is accepted once it has persisted for STABLE_CNT cycles.
        assign accept = differ && (cnt_reg == CNT_MAX);

        always_ff @(posedge clk100_i or negedge rstn_i) begin
            if (!rstn_i) begin
                sync_reg  <= '0;
                cnt_reg   <= '0;
                level_reg <= 1'b0;
                rise_reg  <= 1'b0;
            end else begin
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], ev_i[gi]};
                if (!differ || accept) begin
                    cnt_reg <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
                if (accept) begin
                    level_reg <= sync_s;
                end
                rise_reg <= accept && sync_s;
            end
        end

        assign level_o[gi] = level_reg;
        assign rise_o[gi]  = rise_reg;

`ifdef DEBOUNCE_FALL_EV_EN
        logic fall_reg;

        always_ff @(posedge clk100_i or negedge rstn_i) begin
            if (!rstn_i) begin
                fall_reg <= 1'b0;
            end else begin
                fall_reg <= accept && !sync_s;
            end
        end

        assign fall_o[gi] = fall_reg;
`else
        assign fall_o[gi] = 1'b0;
`endif
    end

endmodule
